// File: rtl/mips_multicycle_control_if.sv
// Control bus between the multicycle control unit and the MIPS32 datapath.
// The control unit is the master: it reads the opcode, zero and mem_ready
// and drives every mux select and enable the datapath consumes.
interface mips_multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             ir_write;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic             i_or_d;
  logic [1:0]       pc_src;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_dst;
  logic             ext_op;
  logic [1:0]       mem_to_reg;
  logic             mul_busy;
  logic             illegal;
  logic             mem_fault;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d,
           pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, ext_op,
           mem_to_reg, mul_busy, illegal, mem_fault, state, instret
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d,
           pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, ext_op,
           mem_to_reg, mul_busy, illegal, mem_fault, state, instret
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS32 control FSM: sequences fetch/decode/execute/memory/
// writeback, waits on a variable-latency memory with a watchdog, counts a
// fixed multiply latency, keeps sticky fault flags and a retired count.
// Outputs are registered from the next state; only pc_write/ir_write carry
// combinational terms (mem_ready in FETCH, zero in BRANCH).
module mips_multicycle_control #(
  parameter int MUL_LATENCY = 4,
  parameter int WAIT_MAX    = 15,
  parameter int CNT_W       = 32
) (
  input logic                       clk,
  input logic                       rst_n,
  mips_multicycle_control_if.master bus
);

  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam int MUL_W  = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_MULT  = 6'b111111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_MULT     = 4'd11,
    S_WB_MULT  = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       ext_op;
    logic [1:0] mem_to_reg;
    logic       mul_busy;
  } ctrl_t;

  // Moore decode of a state; opcode is only consulted where the datapath
  // setting differs per instruction (immediate extension, rd/rt select).
  function automatic ctrl_t decode(state_t st, logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:   begin c.alu_src_b = 2'b11; c.ext_op = 1'b1; end
      S_EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_EXEC_I:   begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11;
        c.ext_op    = (op == OP_ADDI) || (op == OP_SLTI);
      end
      S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.ext_op = 1'b1; end
      S_MEM_RD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEM_WR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_WB_ALU:   begin c.reg_write = 1'b1; c.reg_dst = (op == OP_RTYPE); end
      S_WB_MEM:   begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; end
      S_BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; end
      S_JUMP:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      S_MULT:     c.mul_busy = 1'b1;
      S_WB_MULT:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.mem_to_reg = 2'b10; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  state_t             state_q, nxt;
  ctrl_t              out_q;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [MUL_W-1:0]   mul_q, mul_d;
  logic               illegal_q, mem_fault_q;
  logic [CNT_W-1:0]   instret_q;
  logic               mem_wait, timeout, set_ill, set_mf, retire;
  logic               fetch_done, branch_take;

  // Next state, wait/multiply counters and fault/retire events.
  always_comb begin
    nxt      = state_q;
    wait_d   = '0;
    mul_d    = mul_q;
    set_ill  = 1'b0;
    set_mf   = 1'b0;
    mem_wait = (state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && !bus.mem_ready;
    // The WAIT_MAX-th consecutive idle cycle is the timeout; a ready in
    // that same cycle clears mem_wait and therefore wins.
    timeout  = mem_wait && (WAIT_MAX != 0) && (wait_q == WAIT_W'(WAIT_MAX - 1));
    if (mem_wait && !timeout) wait_d = wait_q + 1'b1;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:                                nxt = S_EXEC_R;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: nxt = S_EXEC_I;
          OP_LW, OP_SW:                            nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                          nxt = S_BRANCH;
          OP_J:                                    nxt = S_JUMP;
          OP_MULT: begin
            nxt   = S_MULT;
            mul_d = MUL_W'(MUL_LATENCY - 1);
          end
          default: begin nxt = S_TRAP; set_ill = 1'b1; end
        endcase
      end
      S_EXEC_R, S_EXEC_I: nxt = S_WB_ALU;
      S_MEM_ADDR: nxt = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (bus.mem_ready) nxt = S_WB_MEM;
      S_MEM_WR:   if (bus.mem_ready) nxt = S_FETCH;
      S_MULT: begin
        if (mul_q == '0) nxt = S_WB_MULT;
        else             mul_d = mul_q - 1'b1;
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_WB_MULT: nxt = S_FETCH;
      S_TRAP:     nxt = S_TRAP;
      default: begin nxt = S_TRAP; set_ill = 1'b1; end
    endcase
    if (timeout) begin
      nxt    = S_TRAP;
      set_mf = 1'b1;
    end
    retire = (nxt == S_FETCH) &&
             (state_q inside {S_WB_ALU, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_WB_MULT});
  end

  // State, counters, sticky flags and registered outputs of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      out_q       <= decode(S_FETCH, 6'd0);
      wait_q      <= '0;
      mul_q       <= '0;
      illegal_q   <= 1'b0;
      mem_fault_q <= 1'b0;
      instret_q   <= '0;
    end else begin
      state_q     <= nxt;
      out_q       <= decode(nxt, bus.opcode);
      wait_q      <= wait_d;
      mul_q       <= mul_d;
      illegal_q   <= illegal_q | set_ill;
      mem_fault_q <= mem_fault_q | set_mf;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  assign fetch_done  = (state_q == S_FETCH) && bus.mem_ready;
  assign branch_take = (bus.opcode == OP_BEQ) ? bus.zero : !bus.zero;

  assign bus.pc_write   = out_q.pc_write | fetch_done | ((state_q == S_BRANCH) && branch_take);
  assign bus.ir_write   = fetch_done;
  assign bus.reg_write  = out_q.reg_write;
  assign bus.mem_read   = out_q.mem_read;
  assign bus.mem_write  = out_q.mem_write;
  assign bus.i_or_d     = out_q.i_or_d;
  assign bus.pc_src     = out_q.pc_src;
  assign bus.alu_src_a  = out_q.alu_src_a;
  assign bus.alu_src_b  = out_q.alu_src_b;
  assign bus.alu_op     = out_q.alu_op;
  assign bus.reg_dst    = out_q.reg_dst;
  assign bus.ext_op     = out_q.ext_op;
  assign bus.mem_to_reg = out_q.mem_to_reg;
  assign bus.mul_busy   = out_q.mul_busy;
  assign bus.illegal    = illegal_q;
  assign bus.mem_fault  = mem_fault_q;
  assign bus.state      = state_q;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: a per-cycle vector table run through a
// scoreboard on a default-parameter instance, then hand sequences for trap
// persistence, reset, watchdog timeout, MUL_LATENCY=1 and instret wrap on a
// second instance (WAIT_MAX=3, CNT_W=2).
module tb_mips_multicycle_control;

  localparam logic [5:0] ADDI = 6'b001000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010;
  localparam logic [5:0] MUL = 6'b111111, RT = 6'b000000, ANDI = 6'b001100;
  localparam logic [5:0] BAD = 6'b110000;

  // mux field order: pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, ext_op, mem_to_reg, mul_busy
  localparam logic [11:0] M_NONE  = 12'b00_0_00_00_0_0_00_0;
  localparam logic [11:0] M_FETCH = 12'b00_0_01_00_0_0_00_0;
  localparam logic [11:0] M_DEC   = 12'b00_0_11_00_0_1_00_0;
  localparam logic [11:0] M_ADDR  = 12'b00_1_10_00_0_1_00_0;
  localparam logic [11:0] M_BR    = 12'b01_1_00_01_0_0_00_0;
  // enable field order: pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d
  localparam logic [5:0] E_FRDY = 6'b110100;

  typedef struct {
    int         id;
    logic       r;
    logic [5:0] op;
    logic       z;
    logic       rdy;
    logic [3:0] st;
    logic [5:0] en;
    logic [11:0] mx;
    logic       ill;
    logic       mf;
    int         ir;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  mips_multicycle_control_if #(.CNT_W(32)) bus_a ();
  mips_multicycle_control_if #(.CNT_W(2))  bus_b ();

  mips_multicycle_control #(.MUL_LATENCY(4), .WAIT_MAX(15), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_a), .bus(bus_a));
  mips_multicycle_control #(.MUL_LATENCY(1), .WAIT_MAX(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(bus_b));

  int n_checks = 0;
  int n_fail = 0;
  vec_t tbl[$];
  vec_t sb[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic r, logic [5:0] op, logic z, logic rdy, logic [3:0] st,
                              logic [5:0] en, logic [11:0] mx, logic ill, logic mf, int ir);
    vec_t v;
    v.id = 0; v.r = r; v.op = op; v.z = z; v.rdy = rdy; v.st = st;
    v.en = en; v.mx = mx; v.ill = ill; v.mf = mf; v.ir = ir;
    return v;
  endfunction

  function automatic logic [5:0] en_a();
    return {bus_a.pc_write, bus_a.ir_write, bus_a.reg_write, bus_a.mem_read, bus_a.mem_write, bus_a.i_or_d};
  endfunction

  function automatic logic [11:0] mx_a();
    return {bus_a.pc_src, bus_a.alu_src_a, bus_a.alu_src_b, bus_a.alu_op, bus_a.reg_dst,
            bus_a.ext_op, bus_a.mem_to_reg, bus_a.mul_busy};
  endfunction

  // Scoreboard side: compare the oldest pending vector mid-cycle.
  always @(negedge clk) begin
    vec_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("row%0d state", e.id), 32'(bus_a.state), 32'(e.st));
      chk($sformatf("row%0d enables", e.id), 32'(en_a()), 32'(e.en));
      chk($sformatf("row%0d muxes", e.id), 32'(mx_a()), 32'(e.mx));
      chk($sformatf("row%0d flags", e.id), 32'({bus_a.illegal, bus_a.mem_fault}), 32'({e.ill, e.mf}));
      chk($sformatf("row%0d instret", e.id), bus_a.instret, 32'(e.ir));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t v;
    bus_a.opcode = ADDI; bus_a.zero = 1'b0; bus_a.mem_ready = 1'b1;
    bus_b.opcode = MUL;  bus_b.zero = 1'b0; bus_b.mem_ready = 1'b0;

    // addi: reset then 0,1,3,7,0
    tbl.push_back(mk(0, ADDI, 0, 1, 0, E_FRDY, M_FETCH, 0, 0, 0));
    tbl.push_back(mk(1, ADDI, 0, 1, 0, E_FRDY, M_FETCH, 0, 0, 0));
    tbl.push_back(mk(1, ADDI, 0, 1, 1, 6'b000000, M_DEC, 0, 0, 0));
    tbl.push_back(mk(1, ADDI, 0, 1, 3, 6'b000000, 12'b00_1_10_11_0_1_00_0, 0, 0, 0));
    tbl.push_back(mk(1, ADDI, 0, 1, 7, 6'b001000, M_NONE, 0, 0, 0));
    // lw with 3 wait cycles in MEM_RD
    tbl.push_back(mk(1, LW, 0, 1, 0, E_FRDY, M_FETCH, 0, 0, 1));
    tbl.push_back(mk(1, LW, 0, 1, 1, 6'b000000, M_DEC, 0, 0, 1));
    tbl.push_back(mk(1, LW, 0, 1, 4, 6'b000000, M_ADDR, 0, 0, 1));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, LW, 0, 0, 5, 6'b000101, M_NONE, 0, 0, 1));
    tbl.push_back(mk(1, LW, 0, 1, 5, 6'b000101, M_NONE, 0, 0, 1));
    tbl.push_back(mk(1, LW, 0, 1, 8, 6'b001000, 12'b00_0_00_00_0_0_01_0, 0, 0, 1));
    // beq zero=0 (not taken), bne zero=0 (taken)
    tbl.push_back(mk(1, BEQ, 0, 1, 0, E_FRDY, M_FETCH, 0, 0, 2));
    tbl.push_back(mk(1, BEQ, 0, 1, 1, 6'b000000, M_DEC, 0, 0, 2));
    tbl.push_back(mk(1, BEQ, 0, 1, 9, 6'b000000, M_BR, 0, 0, 2));
    tbl.push_back(mk(1, BNE, 0, 1, 0, E_FRDY, M_FETCH, 0, 0, 3));
    tbl.push_back(mk(1, BNE, 0, 1, 1, 6'b000000, M_DEC, 0, 0, 3));
    tbl.push_back(mk(1, BNE, 0, 1, 9, 6'b100000, M_BR, 0, 0, 3));
    // mult, MUL_LATENCY=4
    tbl.push_back(mk(1, MUL, 0, 1, 0, E_FRDY, M_FETCH, 0, 0, 4));
    tbl.push_back(mk(1, MUL, 0, 1, 1, 6'b000000, M_DEC, 0, 0, 4));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1, MUL, 0, 1, 11, 6'b000000, 12'b00_0_00_00_0_0_00_1, 0, 0, 4));
    tbl.push_back(mk(1, MUL, 0, 1, 12, 6'b001000, 12'b00_0_00_00_1_0_10_0, 0, 0, 4));
    // R-type
    tbl.push_back(mk(1, RT, 0, 1, 0, E_FRDY, M_FETCH, 0, 0, 5));
    tbl.push_back(mk(1, RT, 0, 1, 1, 6'b000000, M_DEC, 0, 0, 5));
    tbl.push_back(mk(1, RT, 0, 1, 2, 6'b000000, 12'b00_1_00_10_0_0_00_0, 0, 0, 5));
    tbl.push_back(mk(1, RT, 0, 1, 7, 6'b001000, 12'b00_0_00_00_1_0_00_0, 0, 0, 5));
    // sw
    tbl.push_back(mk(1, SW, 0, 1, 0, E_FRDY, M_FETCH, 0, 0, 6));
    tbl.push_back(mk(1, SW, 0, 1, 1, 6'b000000, M_DEC, 0, 0, 6));
    tbl.push_back(mk(1, SW, 0, 1, 4, 6'b000000, M_ADDR, 0, 0, 6));
    tbl.push_back(mk(1, SW, 0, 1, 6, 6'b000011, M_NONE, 0, 0, 6));
    // j
    tbl.push_back(mk(1, JMP, 0, 1, 0, E_FRDY, M_FETCH, 0, 0, 7));
    tbl.push_back(mk(1, JMP, 0, 1, 1, 6'b000000, M_DEC, 0, 0, 7));
    tbl.push_back(mk(1, JMP, 0, 1, 10, 6'b100000, 12'b10_0_00_00_0_0_00_0, 0, 0, 7));
    // andi: zero-extended immediate
    tbl.push_back(mk(1, ANDI, 0, 1, 0, E_FRDY, M_FETCH, 0, 0, 8));
    tbl.push_back(mk(1, ANDI, 0, 1, 1, 6'b000000, M_DEC, 0, 0, 8));
    tbl.push_back(mk(1, ANDI, 0, 1, 3, 6'b000000, 12'b00_1_10_11_0_0_00_0, 0, 0, 8));
    tbl.push_back(mk(1, ANDI, 0, 1, 7, 6'b001000, M_NONE, 0, 0, 8));
    // illegal opcode after one fetch wait cycle
    tbl.push_back(mk(1, BAD, 0, 0, 0, 6'b000100, M_FETCH, 0, 0, 9));
    tbl.push_back(mk(1, BAD, 0, 1, 0, E_FRDY, M_FETCH, 0, 0, 9));
    tbl.push_back(mk(1, BAD, 0, 1, 1, 6'b000000, M_DEC, 0, 0, 9));
    tbl.push_back(mk(1, BAD, 0, 1, 13, 6'b000000, M_NONE, 1, 0, 9));
    tbl.push_back(mk(1, BAD, 1, 1, 13, 6'b000000, M_NONE, 1, 0, 9));

    for (int i = 0; i < tbl.size(); i++) begin
      step();
      v = tbl[i];
      v.id = i;
      rst_a = v.r; bus_a.opcode = v.op; bus_a.zero = v.z; bus_a.mem_ready = v.rdy;
      sb.push_back(v);
    end

    // TRAP is absorbing: 20 cycles with toggling inputs, no enables
    for (int k = 0; k < 20; k++) begin
      step();
      bus_a.mem_ready = k[0]; bus_a.zero = k[1];
      look();
      chk($sformatf("trap%0d state", k), 32'(bus_a.state), 32'd13);
      chk($sformatf("trap%0d enables", k), 32'(en_a()), 32'd0);
      chk($sformatf("trap%0d illegal/instret", k), 32'({bus_a.illegal, bus_a.instret[30:0]}), 32'h8000_0009);
    end

    // asynchronous reset clears the sticky flag and counter immediately
    step();
    bus_a.mem_ready = 1'b1;
    rst_a = 1'b0;
    #1;
    chk("reset illegal", 32'(bus_a.illegal), 32'd0);
    chk("reset state", 32'(bus_a.state), 32'd0);
    chk("reset instret", bus_a.instret, 32'd0);
    chk("reset enables", 32'(en_a()), 32'(E_FRDY));

    // reset in the middle of a load restarts at FETCH
    step();
    rst_a = 1'b1; bus_a.opcode = LW;
    step(); step(); step();
    bus_a.mem_ready = 1'b0;
    look();
    chk("midload state", 32'(bus_a.state), 32'd5);
    rst_a = 1'b0;
    #1;
    chk("midload reset state", 32'(bus_a.state), 32'd0);
    chk("midload reset enables", 32'(en_a()), 32'b000100);
    step();
    rst_a = 1'b1;

    // WAIT_MAX=3: mem_ready held low in FETCH traps after 3 cycles
    rst_b = 1'b1;
    look();
    chk("to c1 state", 32'(bus_b.state), 32'd0);
    step(); look();
    chk("to c2 state/fault", 32'({bus_b.state, bus_b.mem_fault}), 32'({4'd0, 1'b0}));
    step(); look();
    chk("to c3 state/fault", 32'({bus_b.state, bus_b.mem_fault}), 32'({4'd0, 1'b0}));
    step(); look();
    chk("timeout state", 32'(bus_b.state), 32'd13);
    chk("timeout flags", 32'({bus_b.illegal, bus_b.mem_fault}), 32'b01);
    step();
    bus_b.mem_ready = 1'b1;
    look();
    chk("trap ignores ready", 32'({bus_b.pc_write, bus_b.ir_write, bus_b.mem_read}), 32'd0);
    chk("trap fault held", 32'(bus_b.mem_fault), 32'd1);

    // same again with mem_ready rising in the timeout cycle
    step();
    rst_b = 1'b0; bus_b.mem_ready = 1'b0;
    step();
    rst_b = 1'b1;
    look();
    chk("rearm fault clear", 32'(bus_b.mem_fault), 32'd0);
    step(); step();
    bus_b.mem_ready = 1'b1;
    look();
    chk("late ready ir_write", 32'({bus_b.pc_write, bus_b.ir_write}), 32'b11);
    step(); look();
    chk("late ready decode", 32'({bus_b.state, bus_b.mem_fault}), 32'({4'd1, 1'b0}));

    // MUL_LATENCY=1: one busy cycle
    step(); look();
    chk("mul1 busy", 32'({bus_b.state, bus_b.mul_busy}), 32'({4'd11, 1'b1}));
    step(); look();
    chk("mul1 wb", 32'({bus_b.state, bus_b.mul_busy, bus_b.reg_write, bus_b.mem_to_reg}),
        32'({4'd12, 1'b0, 1'b1, 2'b10}));
    step(); look();
    chk("mul1 retire", 32'({bus_b.state, bus_b.instret}), 32'({4'd0, 2'd1}));

    // 2-bit instret wraps modulo 4
    bus_b.opcode = JMP;
    for (int k = 0; k < 3; k++) begin
      step(); step(); step(); look();
      chk($sformatf("wrap j%0d instret", k), 32'(bus_b.instret), 32'((2 + k) % 4));
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle control unit for the MIPS32 core. It replaces the single-cycle opcode decoder with a Moore/Mealy state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It handshakes with a variable-latency memory and applies a watchdog timeout to each memory access. It also counts a parameterised multiply latency and provides sticky fault flags and a retired-instruction counter. It sits between the instruction register/opcode field and the datapath muxes and enables.

## Interface
- MUL_LATENCY, 4, cycles spent in MULT state (>=1)
- WAIT_MAX, 15, max cycles waiting for mem_ready before fault; 0 disables timeout
- CNT_W, 32, width of instret counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]; stable from DECODE until return to FETCH
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write, ir_write, reg_write, mem_read, mem_write  out  1 each  enables
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- pc_src  out  2  00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct decode, 11 immediate op by opcode
- reg_dst, ext_op  out  1 each  rd/rt select; 1 = sign-extend, 0 = zero-extend
- mem_to_reg  out  2  00 ALUOut, 01 memory data, 10 multiplier result
- mul_busy  out  1  high throughout MULT
- illegal, mem_fault  out  1 each  sticky fault flags
- state  out  4  current state code (debug)
- instret  out  CNT_W  retired-instruction count

## Operation
- State codes: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WR 6, WB_ALU 7, WB_MEM 8, BRANCH 9, JUMP 10, MULT 11, WB_MULT 12, TRAP 13. Unused codes go to TRAP.
- Every output not listed for a state is 0.
- FETCH: mem_read=1, alu_src_b=01. When mem_ready=1, assert ir_write=1 and pc_write=1 in the same cycle, then go to DECODE.
- DECODE: alu_src_b=11, ext_op=1. Next state by opcode:
  - 000000 → EXEC_R
  - 001000/001010/001100/001101/001110 (addi/slti/andi/ori/xori) → EXEC_I
  - 100011/101011 (lw/sw) → MEM_ADDR
  - 000100/000101 (beq/bne) → BRANCH
  - 000010 (j) → JUMP
  - 111111 (mult) → MULT
  - any other opcode → TRAP with illegal=1
- EXEC_R: alu_src_a=1, alu_op=10 → WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11. ext_op=1 for addi/slti, 0 for andi/ori/xori. → WB_ALU.
- WB_ALU: reg_write=1, reg_dst=(opcode==0) → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=1 → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, i_or_d=1. On mem_ready → WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=01 → FETCH.
- MEM_WR: mem_write=1, i_or_d=1. On mem_ready → FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_src=01, pc_write = beq ? zero : !zero (Mealy) → FETCH.
- JUMP: pc_src=10, pc_write=1 → FETCH.
- MULT: mul_busy=1 for exactly MUL_LATENCY cycles (down-counter loaded on entry) → WB_MULT.
- WB_MULT: reg_write=1, reg_dst=1, mem_to_reg=10 → FETCH.
- TRAP: absorbing until reset. All enables 0; illegal or mem_fault held high.
- Memory wait counter: counts consecutive cycles in FETCH, MEM_RD or MEM_WR with mem_ready=0, and clears on leaving the state. If WAIT_MAX≠0 and the count reaches WAIT_MAX with mem_ready still 0, go to TRAP and set mem_fault=1.
- mem_ready arriving in the same cycle as the timeout wins: the access completes and no fault is raised.
- instret: +1 on every transition into FETCH from WB_ALU, WB_MEM, MEM_WR, BRANCH, JUMP or WB_MULT, whether or not the branch is taken. Wraps modulo 2^CNT_W.

## Timing
- Async reset: state=FETCH, instret=0, illegal=0, mem_fault=0, counters 0. Outputs are the FETCH decode: mem_read=1, alu_src_b=01, all others 0.
- Only pc_write and ir_write depend combinationally on mem_ready, and only in FETCH. They still follow mem_ready while rst_n is low. The datapath is also held in reset, so this has no effect.
- Reset deasserted mid-instruction restarts at FETCH; any partial memory access is abandoned.
- Cycles per instruction with zero-wait memory (mem_ready tied 1):
  - R-type and immediate ops: 4
  - lw: 5
  - sw: 4
  - beq/bne and j: 3
  - mult: 3+MUL_LATENCY
- Each memory wait cycle adds 1.
- All state, counter and flag updates occur on the rising edge of clk.

## Test plan
- Reset with mem_ready=1, then an addi: state sequence 0,1,3,7,0; reg_write high for 1 cycle with ext_op=1; instret=1 after 4 cycles.
- lw with mem_ready low for 3 cycles in MEM_RD: total 8 cycles; WB_MEM asserts mem_to_reg=01; mem_fault stays 0.
- beq with zero=0, then bne with zero=0: pc_write=0 in the first BRANCH and 1 in the second; instret increments by 2.
- mult with MUL_LATENCY=4: mul_busy high exactly 4 cycles; WB_MULT reg_write=1, mem_to_reg=10; total 7 cycles.
- Opcode 6'b110000: DECODE → TRAP; illegal=1 and held; no enables for 20 cycles; instret frozen. rst_n low clears illegal.
- WAIT_MAX=3 with mem_ready held 0 in FETCH: TRAP after 3 cycles with mem_fault=1. Repeat with mem_ready rising in cycle 3: DECODE is entered and no fault is raised.
